// File: rtl/shift_seq_pkg.sv
// Shared constants and enums for the shift sequencer and its downstream register model.
package shift_seq_pkg;

  localparam int SEQ_W = 4;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ROTL = 2'b01,
    OP_ROTR = 2'b10,
    OP_ASR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/shift_seq_model.sv
// Combinational next-state function of the downstream 4-bit shift register.
import shift_seq_pkg::*;

module shift_model (
  input  logic [SEQ_W-1:0] q,
  input  logic             parallel_loadn,
  input  logic             rotate_right,
  input  logic             as_right,
  input  logic [SEQ_W-1:0] data_in,
  output logic [SEQ_W-1:0] q_next
);

  always_comb begin
    q_next = q;
    if (!parallel_loadn) begin
      q_next = data_in;
    end else if (!rotate_right) begin
      q_next = {q[SEQ_W-2:0], q[SEQ_W-1]};
    end else if (!as_right) begin
      q_next = {q[0], q[SEQ_W-1:1]};
    end else begin
      q_next = {q[SEQ_W-1], q[SEQ_W-1:1]};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer that steers a downstream shift register and tracks its contents in shadow_q.
import shift_seq_pkg::*;

module shift_sequencer (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [SEQ_W-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             ParallelLoadn,
  output logic             RotateRight,
  output logic             ASRight,
  output logic [SEQ_W-1:0] Data_IN,
  output logic [SEQ_W-1:0] shadow_q,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [SEQ_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEQ_W-1:0] shadow_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LOAD;
      data_q   <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          data_d = cmd_data;
          cnt_d  = cmd_count;
          if (op_e'(cmd_op) == OP_LOAD) begin
            state_d = ST_LOAD;
          end else if (cmd_count != '0) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: state_d = ST_DONE;
      ST_SHIFT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outside SHIFT the register reloads its own value, so it holds.
  always_comb begin
    ParallelLoadn = 1'b0;
    RotateRight   = 1'b1;
    ASRight       = 1'b1;
    Data_IN       = shadow_q;
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE);
    cmd_ready     = (state_q == ST_IDLE);
    case (state_q)
      ST_LOAD: Data_IN = data_q;
      ST_SHIFT: begin
        ParallelLoadn = 1'b1;
        case (op_q)
          OP_ROTL: RotateRight = 1'b0;
          OP_ROTR: ASRight     = 1'b0;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  shift_model u_model (
    .q              (shadow_q),
    .parallel_loadn (ParallelLoadn),
    .rotate_right   (RotateRight),
    .as_right       (ASRight),
    .data_in        (Data_IN),
    .q_next         (shadow_d)
  );

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus queues expected completions, a monitor checks each done pulse.
module tb_shift_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_count;
  logic       ParallelLoadn;
  logic       RotateRight;
  logic       ASRight;
  logic [3:0] Data_IN;
  logic [3:0] shadow_q;
  logic       busy;
  logic       done;

  typedef struct {
    logic [3:0] shadow;
    int         cyc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc1, acc2, acc_tmp;

  shift_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .cmd_count     (cmd_count),
    .ParallelLoadn (ParallelLoadn),
    .RotateRight   (RotateRight),
    .ASRight       (ASRight),
    .Data_IN       (Data_IN),
    .shadow_q      (shadow_q),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a command, wait (bounded) until it is accepted, and optionally queue its completion.
  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [3:0] data,
                               input logic [2:0] count, input logic [3:0] exp_shadow, input int lat,
                               input bit push, input bit keep, output int acc);
    int waited = 0;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = count;
    while (cmd_ready !== 1'b1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s accept: got no cmd_ready, want accept within 50 cycles", name);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clock);
    #1;
    acc = cyc;
    if (push) sb.push_back('{exp_shadow, acc + lat, name});
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int waited = 0;
    @(negedge clock);
    while (cmd_ready !== 1'b1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s idle: got busy, want idle within 50 cycles", name);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued completion, both value and timing.
  always @(negedge clock) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected done: got done=1, want no completion pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        vectors++;
        if (shadow_q !== e.shadow) begin
          miscompares++;
          $display("[TB] FAIL %s shadow: got %b, want %b", e.name, shadow_q, e.shadow);
        end
        vectors++;
        if (cyc != e.cyc) begin
          miscompares++;
          $display("[TB] FAIL %s done cycle: got %0d, want %0d", e.name, cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'h0;
    cmd_count = 3'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    $display("[TB] reset checks");
    checkOutput("reset cmd_ready", 8'(cmd_ready), 8'd1);
    checkOutput("reset busy", 8'(busy), 8'd0);
    checkOutput("reset done", 8'(done), 8'd0);
    checkOutput("reset ParallelLoadn", 8'(ParallelLoadn), 8'd0);
    checkOutput("reset Data_IN", 8'(Data_IN), 8'h0);
    checkOutput("reset RotateRight", 8'(RotateRight), 8'd1);
    checkOutput("reset ASRight", 8'(ASRight), 8'd1);
    checkOutput("reset shadow_q", 8'(shadow_q), 8'h0);
    reset = 1'b0;

    // LOAD 1001: LOAD state drives the data with ParallelLoadn low
    applyStimulus("load 1001", 2'b00, 4'b1001, 3'd0, 4'b1001, 1, 1'b1, 1'b0, acc_tmp);
    checkOutput("load ParallelLoadn", 8'(ParallelLoadn), 8'd0);
    checkOutput("load Data_IN", 8'(Data_IN), 8'b1001);
    checkOutput("load busy", 8'(busy), 8'd1);
    checkOutput("load cmd_ready", 8'(cmd_ready), 8'd0);
    waitIdle("load 1001");

    applyStimulus("rotl1 1001", 2'b01, 4'hF, 3'd1, 4'b0011, 1, 1'b1, 1'b0, acc_tmp);
    waitIdle("rotl1");

    applyStimulus("load 1001b", 2'b00, 4'b1001, 3'd0, 4'b1001, 1, 1'b1, 1'b0, acc_tmp);
    waitIdle("load 1001b");
    applyStimulus("rotr1 1001", 2'b10, 4'h0, 3'd1, 4'b1100, 1, 1'b1, 1'b0, acc_tmp);
    waitIdle("rotr1");

    // ASR x3 from 1000 with the per-step shadow sequence, then a 5-cycle hold
    applyStimulus("load 1000", 2'b00, 4'b1000, 3'd0, 4'b1000, 1, 1'b1, 1'b0, acc_tmp);
    waitIdle("load 1000");
    applyStimulus("asr3 1000", 2'b11, 4'h0, 3'd3, 4'b1111, 3, 1'b1, 1'b0, acc_tmp);
    @(negedge clock);
    checkOutput("asr ParallelLoadn", 8'(ParallelLoadn), 8'd1);
    checkOutput("asr RotateRight", 8'(RotateRight), 8'd1);
    checkOutput("asr ASRight", 8'(ASRight), 8'd1);
    @(negedge clock);
    checkOutput("asr step1", 8'(shadow_q), 8'b1100);
    @(negedge clock);
    checkOutput("asr step2", 8'(shadow_q), 8'b1110);
    @(negedge clock);
    checkOutput("asr step3", 8'(shadow_q), 8'b1111);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("asr hold", 8'(shadow_q), 8'b1111);
      checkOutput("hold done", 8'(done), 8'd0);
    end

    // count 0 goes straight to DONE with the shadow unchanged
    applyStimulus("rotl0", 2'b01, 4'h0, 3'd0, 4'b1111, 0, 1'b1, 1'b0, acc_tmp);
    waitIdle("rotl0");

    // second op held on the bus while busy: accepted only after DONE
    applyStimulus("load 0110 held", 2'b00, 4'b0110, 3'd0, 4'b0110, 1, 1'b1, 1'b1, acc1);
    applyStimulus("rotr2 0110", 2'b10, 4'b1111, 3'd2, 4'b1001, 2, 1'b1, 1'b0, acc2);
    vectors++;
    if (acc2 != acc1 + 3) begin
      miscompares++;
      $display("[TB] FAIL back-to-back accept: got cycle %0d, want %0d", acc2, acc1 + 3);
    end
    waitIdle("rotr2");

    // reset in the 2nd SHIFT cycle of ROTR x5 aborts without a done pulse
    applyStimulus("load 1010", 2'b00, 4'b1010, 3'd0, 4'b1010, 1, 1'b1, 1'b0, acc_tmp);
    waitIdle("load 1010");
    applyStimulus("rotr5 abort", 2'b10, 4'h0, 3'd5, 4'h0, 5, 1'b0, 1'b0, acc_tmp);
    @(negedge clock);
    @(negedge clock);
    checkOutput("abort busy before reset", 8'(busy), 8'd1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abort shadow", 8'(shadow_q), 8'h0);
    checkOutput("abort busy", 8'(busy), 8'd0);
    checkOutput("abort done", 8'(done), 8'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post-release shadow", 8'(shadow_q), 8'h0);
    checkOutput("post-release cmd_ready", 8'(cmd_ready), 8'd1);
    repeat (8) @(negedge clock);

    applyStimulus("load 0101 recover", 2'b00, 4'b0101, 3'd0, 4'b0101, 1, 1'b1, 1'b0, acc_tmp);
    waitIdle("load 0101");
    repeat (3) @(negedge clock);
    checkOutput("scoreboard drained", 8'(sb.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
